// File: rtl/ser_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ser_fifo
//  Description : 8N1 UART with receive/transmit FIFOs, programmable 16-bit
//                baud divisor, sticky error flags and level interrupts,
//                accessed over a single-cycle internal I/O bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module ser_fifo #(
    parameter int          DEPTH_LOG2 = 4,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stb,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       ack,
    output logic       irq_r,
    output logic       irq_t,
    input  logic       rxd,
    output logic       txd
);

    localparam int                  c_DEPTH_I = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH   = c_DEPTH_I[DEPTH_LOG2:0];

    localparam logic [2:0] c_RX_IDLE  = 3'd0;
    localparam logic [2:0] c_RX_START = 3'd1;
    localparam logic [2:0] c_RX_DATA  = 3'd2;
    localparam logic [2:0] c_RX_STOP  = 3'd3;
    localparam logic [2:0] c_RX_WAIT  = 3'd4;

    localparam logic [1:0] c_TX_IDLE  = 2'd0;
    localparam logic [1:0] c_TX_START = 2'd1;
    localparam logic [1:0] c_TX_DATA  = 2'd2;
    localparam logic [1:0] c_TX_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]            r_rx_mem [c_DEPTH_I];
    logic [DEPTH_LOG2-1:0] r_rx_wp, r_rx_rp;
    logic [DEPTH_LOG2:0]   r_rx_lvl;
    logic [7:0]            r_tx_mem [c_DEPTH_I];
    logic [DEPTH_LOG2-1:0] r_tx_wp, r_tx_rp;
    logic [DEPTH_LOG2:0]   r_tx_lvl;

    logic        r_rx_ien, r_tx_ien, r_ovr, r_ferr;
    logic [15:0] r_div;

    logic        r_rxd_s1, r_rxd_s2;
    logic [2:0]  r_rx_state;
    logic [15:0] r_rx_cnt, r_rx_div;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_sh;

    logic [1:0]  r_tx_state;
    logic [15:0] r_tx_cnt, r_tx_div;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_sh;
    logic        r_txd;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic        w_rd, w_wr;
    logic        w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_tick;
    logic        w_rx_stop_evt, w_rx_ovr, w_rx_ferr;
    logic        w_tx_empty, w_tx_full, w_tx_pop, w_tx_push, w_tx_tick, w_tx_load;
    logic        w_tx_idle;
    logic [15:0] w_div_eff;

    assign w_rd       = stb & ~we;
    assign w_wr       = stb & we;
    assign w_div_eff  = (r_div < 16'd2) ? 16'd2 : r_div;

    assign w_rx_empty    = (r_rx_lvl == '0);
    assign w_rx_full     = (r_rx_lvl == c_DEPTH);
    assign w_rx_pop      = w_rd & (addr == 3'd1) & ~w_rx_empty;
    assign w_rx_tick     = (r_rx_cnt == 16'd0);
    assign w_rx_stop_evt = (r_rx_state == c_RX_STOP) & w_rx_tick;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_rx_push     = w_rx_stop_evt & r_rxd_s2 & (~w_rx_full | w_rx_pop);
    assign w_rx_ovr      = w_rx_stop_evt & r_rxd_s2 & w_rx_full & ~w_rx_pop;
    assign w_rx_ferr     = w_rx_stop_evt & ~r_rxd_s2;

    assign w_tx_empty = (r_tx_lvl == '0);
    assign w_tx_full  = (r_tx_lvl == c_DEPTH);
    assign w_tx_tick  = (r_tx_cnt == 16'd0);
    // Next byte is taken when idle, or at the end of a stop bit (no gap).
    assign w_tx_load  = ~w_tx_empty & ((r_tx_state == c_TX_IDLE) |
                                       ((r_tx_state == c_TX_STOP) & w_tx_tick));
    assign w_tx_pop   = w_tx_load;
    assign w_tx_push  = w_wr & (addr == 3'd3) & (~w_tx_full | w_tx_pop);
    assign w_tx_idle  = w_tx_empty & (r_tx_state == c_TX_IDLE);

    assign ack   = stb;
    assign irq_r = r_rx_ien & ~w_rx_empty;
    assign irq_t = r_tx_ien & ~w_tx_full;
    assign txd   = r_txd;

    // Register read mux; write-only and unused locations read as zero
    always_comb begin
        data_out = 8'h00;
        case (addr)
            3'd0: data_out = {4'b0000, r_ferr, r_ovr, r_rx_ien, ~w_rx_empty};
            3'd1: data_out = r_rx_mem[r_rx_rp];
            3'd2: data_out = {5'b00000, w_tx_idle, r_tx_ien, ~w_tx_full};
            3'd4: data_out = r_div[7:0];
            3'd5: data_out = r_div[15:8];
            3'd6: data_out = 8'(r_rx_lvl);
            3'd7: data_out = 8'(r_tx_lvl);
            default: data_out = 8'h00;
        endcase
    end

    // Control/status registers: enables, divisor, sticky errors (set wins over W1C)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_ien <= 1'b0;
            r_tx_ien <= 1'b0;
            r_ovr    <= 1'b0;
            r_ferr   <= 1'b0;
            r_div    <= DIV_RESET;
        end else begin
            if (w_wr && addr == 3'd0) r_rx_ien <= data_in[1];
            if (w_wr && addr == 3'd2) r_tx_ien <= data_in[1];
            if (w_wr && addr == 3'd4) r_div[7:0]  <= data_in;
            if (w_wr && addr == 3'd5) r_div[15:8] <= data_in;
            if (w_rx_ovr)                              r_ovr <= 1'b1;
            else if (w_wr && addr == 3'd0 && data_in[2]) r_ovr <= 1'b0;
            if (w_rx_ferr)                             r_ferr <= 1'b1;
            else if (w_wr && addr == 3'd0 && data_in[3]) r_ferr <= 1'b0;
        end
    end

    // FIFO storage (contents need no reset; pointers define validity)
    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= data_in;
    end

    // Receive FIFO pointers and level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_lvl <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_lvl <= r_rx_lvl + 1'b1;
                2'b01:   r_rx_lvl <= r_rx_lvl - 1'b1;
                default: r_rx_lvl <= r_rx_lvl;
            endcase
        end
    end

    // Transmit FIFO pointers and level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_lvl <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_lvl <= r_tx_lvl + 1'b1;
                2'b01:   r_tx_lvl <= r_tx_lvl - 1'b1;
                default: r_tx_lvl <= r_tx_lvl;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxd_s1 <= 1'b1;
            r_rxd_s2 <= 1'b1;
        end else begin
            r_rxd_s1 <= rxd;
            r_rxd_s2 <= r_rxd_s1;
        end
    end

    // Receiver: IDLE is only left from a high line, so a low level there is
    // the start edge; timing is latched per character.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= c_RX_IDLE;
            r_rx_cnt   <= 16'd0;
            r_rx_div   <= 16'd2;
            r_rx_bit   <= 3'd0;
            r_rx_sh    <= 8'h00;
        end else begin
            case (r_rx_state)
                c_RX_IDLE: begin
                    if (!r_rxd_s2) begin
                        r_rx_state <= c_RX_START;
                        r_rx_div   <= w_div_eff;
                        r_rx_cnt   <= (w_div_eff >> 1) - 16'd1;
                    end
                end
                c_RX_START: begin
                    if (w_rx_tick) begin
                        if (!r_rxd_s2) begin
                            r_rx_state <= c_RX_DATA;
                            r_rx_cnt   <= r_rx_div - 16'd1;
                            r_rx_bit   <= 3'd0;
                        end else begin
                            r_rx_state <= c_RX_IDLE;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                c_RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_sh  <= {r_rxd_s2, r_rx_sh[7:1]};
                        r_rx_cnt <= r_rx_div - 16'd1;
                        if (r_rx_bit == 3'd7) r_rx_state <= c_RX_STOP;
                        else                  r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 16'd1;
                    end
                end
                c_RX_STOP: begin
                    if (w_rx_tick) r_rx_state <= r_rxd_s2 ? c_RX_IDLE : c_RX_WAIT;
                    else           r_rx_cnt   <= r_rx_cnt - 16'd1;
                end
                c_RX_WAIT: begin
                    if (r_rxd_s2) r_rx_state <= c_RX_IDLE;
                end
                default: r_rx_state <= c_RX_IDLE;
            endcase
        end
    end

    // Transmitter: registered txd, back-to-back characters when data waits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= c_TX_IDLE;
            r_tx_cnt   <= 16'd0;
            r_tx_div   <= 16'd2;
            r_tx_bit   <= 3'd0;
            r_tx_sh    <= 8'h00;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                c_TX_START: begin
                    if (w_tx_tick) begin
                        r_txd      <= r_tx_sh[0];
                        r_tx_cnt   <= r_tx_div - 16'd1;
                        r_tx_bit   <= 3'd0;
                        r_tx_state <= c_TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                c_TX_DATA: begin
                    if (w_tx_tick) begin
                        r_tx_cnt <= r_tx_div - 16'd1;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= c_TX_STOP;
                        end else begin
                            r_tx_bit <= r_tx_bit + 3'd1;
                            r_tx_sh  <= r_tx_sh >> 1;
                            r_txd    <= r_tx_sh[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt - 16'd1;
                    end
                end
                c_TX_STOP: begin
                    if (!w_tx_tick)      r_tx_cnt   <= r_tx_cnt - 16'd1;
                    else if (!w_tx_load) r_tx_state <= c_TX_IDLE;
                end
                default: ;
            endcase
            // Start of a new character from IDLE or end of stop bit
            if (w_tx_load) begin
                r_tx_sh    <= r_tx_mem[r_tx_rp];
                r_txd      <= 1'b0;
                r_tx_div   <= w_div_eff;
                r_tx_cnt   <= w_div_eff - 16'd1;
                r_tx_state <= c_TX_START;
            end
        end
    end

endmodule
`default_nettype wire
